maxpool2d_stage: RTL and testbench
==================================

MAXPOOL2D_STAGE -- requirements
Module: maxpool2d_stage

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 16, signed sample width; IN_DIM, default 26, input feature-map side; NUM_CH, default 16, channel count; POOL, fixed 2, window side and stride.
REQ-002 The block SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inmem_wantwrite  in  1  upstream write strobe into the input memory.
- in_index  in  3x16  {ch, y, x} write address.
- in_data  in  DATA_W  signed sample.
- compute_start  in  1  one-cycle start pulse.
- compute_done  out  1  one-cycle completion pulse.
- out_valid  out  1  pooled sample valid.
- out_ready  in  1  downstream accept.
- out_index  out  3x16  {ch, y, x} output address, 0..IN_DIM/2-1.
- out_data  out  DATA_W  pooled sample.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, READ, EMIT, DONE.
REQ-004 IDLE SHALL move to LOAD on the first inmem_wantwrite; LOAD SHALL store in_data at (ch*IN_DIM+y)*IN_DIM+x on every cycle with inmem_wantwrite=1.
REQ-005 Writes with any index coordinate out of range SHALL be dropped silently.
REQ-006 compute_start in IDLE or LOAD SHALL clear the output counters and enter READ; compute_start in READ, EMIT or DONE SHALL be ignored.
REQ-007 Writes in READ, EMIT or DONE SHALL be ignored.
REQ-008 READ SHALL issue the four window addresses (2y,2x), (2y,2x+1), (2y+1,2x), (2y+1,2x+1) on four consecutive cycles.
REQ-009 Memory read SHALL be synchronous with one-cycle latency.
REQ-010 The first returned word SHALL load the running max; the next three SHALL be compared signed (ties keep the earlier value).
REQ-011 out_valid SHALL rise the cycle after the fourth word returns, which is 5 cycles after the first read address.
REQ-012 out_valid, out_data and out_index SHALL hold stable until the cycle out_valid&&out_ready is true.
REQ-013 On acceptance the block SHALL advance x, then y, then ch, and return to READ with no bubble.
REQ-014 An odd IN_DIM SHALL be handled by floor(IN_DIM/2): the last row and column are unused.
REQ-015 Acceptance of output (ch=NUM_CH-1, y=x=IN_DIM/2-1) SHALL enter DONE.
REQ-016 DONE SHALL pulse compute_done for exactly one cycle, then return to IDLE.
REQ-017 Memory contents SHALL persist across frames.

Reset
REQ-018 Asserting reset (low) SHALL immediately force IDLE, with compute_done=0, out_valid=0, out_data=0, out_index=0 and all counters 0, even mid-frame.
REQ-019 Reset SHALL NOT clear memory contents.
REQ-020 A frame interrupted by reset SHALL NOT produce compute_done.

Configuration
REQ-021 With RELU_FUSE_EN defined, out_data SHALL equal max(pooled, 0); without it, out_data SHALL be the raw signed maximum.
REQ-022 Latency SHALL be identical in both builds.

Structure
REQ-023 DATA_W, the default dimensions and the FSM state enum SHALL live in the shared package cnn_pkg.
REQ-024 The storage SHALL be one sub-module, pool_inmem: single write port, single synchronous read port, depth NUM_CH*IN_DIM*IN_DIM.

Verification
REQ-025 Load ch0 with value x+y*26, out_ready=1, then start -> output (0,0,0)=27 and (0,12,12)=675, out_valid 5 cycles after the first READ address.
REQ-026 Window {-5,-3,-9,-4} -> out_data=-3 without RELU_FUSE_EN, out_data=0 with it.
REQ-027 out_ready held low for 10 cycles on the first output -> out_valid, out_data and out_index stable throughout, and no counter advance.
REQ-028 Full 16x26x26 load, start, out_ready=1 -> exactly 2704 outputs, compute_done one cycle after the last accept, then IDLE.
REQ-029 reset pulsed low mid-READ -> outputs 0 next edge, no compute_done; a re-start without reload reproduces the original outputs.
REQ-030 Write to x=26 and compute_start during EMIT -> memory unchanged, and the output sequence is unaffected.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, index payload and FSM state type for the CNN stages.
//   DATA_W      default signed sample width
//   DEF_IN_DIM  default input feature-map side
//   DEF_NUM_CH  default channel count
//   POOL        pooling window side and stride (fixed)
package cnn_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DEF_IN_DIM = 26;
    localparam int unsigned DEF_NUM_CH = 16;
    localparam int unsigned POOL       = 2;
    localparam int unsigned IDX_W      = 16;

    // {ch, y, x} feature-map coordinate
    typedef struct packed {
        logic [IDX_W-1:0] ch;
        logic [IDX_W-1:0] y;
        logic [IDX_W-1:0] x;
    } idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/maxpool2d_stage_if.sv
// maxpool2d_stage_if: load / control / pooled-output bus of the max-pool stage.
//   inmem_wantwrite, in_index, in_data   upstream writes into the input memory
//   compute_start, compute_done          frame start pulse / completion pulse
//   out_valid, out_ready, out_index, out_data   pooled sample stream
// Modports: master = upstream/downstream environment, slave = pooling stage.
interface maxpool2d_stage_if #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W
);
    import cnn_pkg::*;

    logic                     inmem_wantwrite;
    idx_t                     in_index;
    logic signed [DATA_W-1:0] in_data;
    logic                     compute_start;
    logic                     compute_done;
    logic                     out_valid;
    logic                     out_ready;
    idx_t                     out_index;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output inmem_wantwrite, in_index, in_data, compute_start, out_ready,
        input  compute_done, out_valid, out_index, out_data
    );

    modport slave (
        input  inmem_wantwrite, in_index, in_data, compute_start, out_ready,
        output compute_done, out_valid, out_index, out_data
    );

endinterface

// File: rtl/pool_inmem.sv
// pool_inmem: input feature-map storage, one write port and one synchronous
// read port (one-cycle latency). Contents are never reset.
//   clk              clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read request, rd_data valid the following cycle
module pool_inmem #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    // Storage array and registered read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/maxpool2d_stage.sv
// maxpool2d_stage: loads a NUM_CH x IN_DIM x IN_DIM signed feature map, then
// streams the 2x2 / stride-2 max-pooled map in x, y, ch order over a
// valid/ready handshake.
//   clk     clock, rising edge
//   reset   asynchronous active-low reset (memory contents are kept)
//   bus     maxpool2d_stage_if.slave (load port, start/done, output stream)
// Build option: define RELU_FUSE_EN to clamp pooled outputs at zero.
module maxpool2d_stage #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned IN_DIM = cnn_pkg::DEF_IN_DIM,
    parameter int unsigned NUM_CH = cnn_pkg::DEF_NUM_CH
) (
    input logic              clk,
    input logic              reset,
    maxpool2d_stage_if.slave bus
);
    import cnn_pkg::*;

    localparam int unsigned OUT_DIM = IN_DIM / POOL;
    localparam int unsigned DEPTH   = NUM_CH * IN_DIM * IN_DIM;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);

    state_e state, state_next;

    logic [IDX_W-1:0]         ch_q, y_q, x_q;
    logic [2:0]               phase_q;
    logic signed [DATA_W-1:0] run_max_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_valid_q;
    logic                     compute_done_q;

    logic                     in_range_c;
    logic                     wr_en_c;
    logic [ADDR_W-1:0]        wr_addr_c;
    logic                     rd_en_c;
    logic [ADDR_W-1:0]        rd_addr_c;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] final_max_c;
    logic signed [DATA_W-1:0] pooled_c;
    logic                     accept_c;
    logic                     last_win_c;

    // Write port: only while loading, only in-range coordinates
    assign in_range_c = (32'(bus.in_index.ch) < NUM_CH) &&
                        (32'(bus.in_index.y)  < IN_DIM) &&
                        (32'(bus.in_index.x)  < IN_DIM);
    assign wr_en_c    = bus.inmem_wantwrite && in_range_c &&
                        ((state == IDLE) || (state == LOAD));
    assign wr_addr_c  = ADDR_W'((32'(bus.in_index.ch) * IN_DIM + 32'(bus.in_index.y)) * IN_DIM
                                + 32'(bus.in_index.x));

    // Read port: phases 0..3 walk the window row-major, phase 4 drains the last word
    assign rd_en_c   = (state == READ) && (phase_q < 3'd4);
    assign rd_addr_c = ADDR_W'((32'(ch_q) * IN_DIM + 32'(y_q) * POOL + 32'(phase_q[1])) * IN_DIM
                               + 32'(x_q) * POOL + 32'(phase_q[0]));

    pool_inmem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_inmem (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (bus.in_data),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    // Strictly-greater compare so ties keep the earlier word
    assign final_max_c = (rd_data > run_max_q) ? rd_data : run_max_q;

`ifdef RELU_FUSE_EN
    assign pooled_c = final_max_c[DATA_W-1] ? '0 : final_max_c;
`else
    assign pooled_c = final_max_c;
`endif

    assign accept_c   = out_valid_q && bus.out_ready;
    assign last_win_c = (32'(ch_q) == NUM_CH - 1) &&
                        (32'(y_q)  == OUT_DIM - 1) &&
                        (32'(x_q)  == OUT_DIM - 1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.compute_start) begin
                    state_next = READ;
                end else if (bus.inmem_wantwrite) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (bus.compute_start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (phase_q == 3'd4) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (accept_c) begin
                    state_next = last_win_c ? DONE : READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window counters, running max and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q           <= '0;
            y_q            <= '0;
            x_q            <= '0;
            phase_q        <= '0;
            run_max_q      <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            compute_done_q <= 1'b0;
        end else begin
            out_valid_q    <= (state_next == EMIT);
            compute_done_q <= (state_next == DONE);
            case (state)
                IDLE, LOAD: begin
                    if (bus.compute_start) begin
                        ch_q    <= '0;
                        y_q     <= '0;
                        x_q     <= '0;
                        phase_q <= '0;
                    end
                end
                READ: begin
                    phase_q <= (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
                    case (phase_q)
                        3'd1:       run_max_q  <= rd_data;
                        3'd2, 3'd3: run_max_q  <= final_max_c;
                        3'd4:       out_data_q <= pooled_c;
                        default:    ;
                    endcase
                end
                EMIT: begin
                    // Advance x, then y, then ch; the last window wraps all to zero
                    if (accept_c) begin
                        if (32'(x_q) == OUT_DIM - 1) begin
                            x_q <= '0;
                            if (32'(y_q) == OUT_DIM - 1) begin
                                y_q  <= '0;
                                ch_q <= (32'(ch_q) == NUM_CH - 1) ? '0 : ch_q + IDX_W'(1);
                            end else begin
                                y_q <= y_q + IDX_W'(1);
                            end
                        end else begin
                            x_q <= x_q + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_index    = '{ch: ch_q, y: y_q, x: x_q};
    assign bus.compute_done = compute_done_q;

endmodule

// File: tb/tb_maxpool2d_stage.sv
// tb_maxpool2d_stage: randomized load/pool frames against a window-max
// reference model, with a scoreboard queue checked by an output monitor.
`timescale 1ns/1ps
module tb_maxpool2d_stage;
    import cnn_pkg::*;

    localparam int unsigned DW     = DATA_W;
    localparam int unsigned DIM    = DEF_IN_DIM;
    localparam int unsigned NCH    = DEF_NUM_CH;
    localparam int unsigned ODIM   = DIM / 2;
    localparam int unsigned NOUT   = NCH * ODIM * ODIM;
    localparam int          BUDGET = 40000;

    typedef struct packed {
        idx_t          idx;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    maxpool2d_stage_if #(.DATA_W(DW)) bus ();

    maxpool2d_stage #(
        .DATA_W (DW),
        .IN_DIM (DIM),
        .NUM_CH (NCH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   done_due  = -1;
    int   out_cnt   = 0;
    bit   done_seen = 1'b0;
    exp_t sb[$];

    logic signed [DW-1:0] mem_m [NCH][DIM][DIM];

    bit            hold_prev = 1'b0;
    idx_t          prev_idx;
    logic [DW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain max over the 2x2 window, optionally clamped at zero
    function automatic logic [DW-1:0] ref_pool(input int c, input int y, input int x);
        logic signed [DW-1:0] m;
        m = mem_m[c][2*y][2*x];
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                if (mem_m[c][2*y+dy][2*x+dx] > m) m = mem_m[c][2*y+dy][2*x+dx];
            end
        end
`ifdef RELU_FUSE_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.out_valid && hold_prev) begin
                check("hold_data", 64'({bus.out_data}), 64'(prev_data));
                check("hold_index", 64'(bus.out_index), 64'(prev_idx));
            end
            if (bus.compute_done || cyc == done_due) begin
                check("done_pulse", 64'(bus.compute_done), 64'(cyc == done_due));
                if (bus.compute_done) begin
                    done_seen = 1'b1;
                    check("done_out_count", 64'(out_cnt), 64'(NOUT));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: index=0x%0h data=0x%0h at %0t",
                             bus.out_index, bus.out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("out_index", 64'(bus.out_index), 64'(e.idx));
                    check("out_data", 64'({bus.out_data}), 64'(e.data));
                    out_cnt++;
                    if (sb.size() == 0) done_due = cyc + 1;
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_idx  = bus.out_index;
            prev_data = bus.out_data;
        end
    end

    task automatic mem_write(input int c, input int y, input int x, input logic signed [DW-1:0] v);
        bus.inmem_wantwrite = 1'b1;
        bus.in_index        = '{ch: 16'(c), y: 16'(y), x: 16'(x)};
        bus.in_data         = v;
        @(posedge clk); #1;
        bus.inmem_wantwrite = 1'b0;
        if (c < int'(NCH) && y < int'(DIM) && x < int'(DIM)) mem_m[c][y][x] = v;
    endtask

    task automatic start_frame();
        exp_t e;
        for (int c = 0; c < int'(NCH); c++) begin
            for (int y = 0; y < int'(ODIM); y++) begin
                for (int x = 0; x < int'(ODIM); x++) begin
                    e.idx  = '{ch: 16'(c), y: 16'(y), x: 16'(x)};
                    e.data = ref_pool(c, y, x);
                    sb.push_back(e);
                end
            end
        end
        out_cnt   = 0;
        done_seen = 1'b0;
        bus.compute_start = 1'b1;
        @(posedge clk); #1;
        bus.compute_start = 1'b0;
    endtask

    // Random backpressure; optional ignored writes/starts while the frame is busy
    task automatic run_to_done(input bit inject);
        int n = 0;
        while (!done_seen && n < BUDGET) begin
            bus.out_ready = ($urandom_range(7) != 0);
            if (inject && sb.size() > 1) begin
                bus.inmem_wantwrite = ($urandom_range(7) == 0);
                bus.in_index = '{ch: 16'($urandom_range(NCH-1)), y: 16'($urandom_range(DIM-1)),
                                 x: 16'($urandom_range(DIM-1))};
                bus.in_data  = DW'($urandom);
                bus.compute_start = ($urandom_range(31) == 0);
            end else begin
                bus.inmem_wantwrite = 1'b0;
                bus.compute_start   = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.inmem_wantwrite = 1'b0;
        bus.compute_start   = 1'b0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: outputs=%0d of %0d", out_cnt, NOUT);
        end
        check("frame_outputs", 64'(out_cnt), 64'(NOUT));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int win[4] = '{-5, -3, -9, -4};
        int n;
        logic signed [DW-1:0] v;

        bus.inmem_wantwrite = 1'b0;
        bus.in_index        = '0;
        bus.in_data         = '0;
        bus.compute_start   = 1'b0;
        bus.out_ready       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_compute_done", 64'(bus.compute_done), 64'(0));
        check("rst_out_data", 64'({bus.out_data}), 64'(0));
        check("rst_out_index", 64'(bus.out_index), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Full load: ch0 ramp, ch1 window (0,0) negative, rest random
        for (int c = 0; c < int'(NCH); c++) begin
            for (int y = 0; y < int'(DIM); y++) begin
                for (int x = 0; x < int'(DIM); x++) begin
                    if (c == 0) v = DW'(x + y * int'(DIM));
                    else if (c == 1 && y < 2 && x < 2) v = DW'(win[y*2+x]);
                    else v = DW'($urandom);
                    mem_write(c, y, x, v);
                    if ($urandom_range(7) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
        // Out-of-range writes must be dropped (several would alias real cells)
        mem_write(0, 0, int'(DIM), DW'(16'sh7fff));
        mem_write(0, 5, int'(DIM), DW'(16'sh7fff));
        mem_write(0, int'(DIM), 0, DW'(16'sh7fff));
        mem_write(int'(NCH), 0, 0, DW'(16'sh7fff));
        mem_write(65535, 65535, 65535, DW'(16'sh7fff));

        // Frame A: latency, 10-cycle hold, ignored write/start in EMIT
        bus.out_ready = 1'b0;
        start_frame();
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_latency", 64'(n), 64'(5));
        repeat (10) @(posedge clk);
        #1;
        bus.inmem_wantwrite = 1'b1;
        bus.in_index        = '{ch: 16'd0, y: 16'd0, x: 16'd26};
        bus.in_data         = DW'(16'sh7fff);
        bus.compute_start   = 1'b1;
        @(posedge clk); #1;
        bus.in_index        = '{ch: 16'd0, y: 16'd0, x: 16'd0};
        @(posedge clk); #1;
        bus.inmem_wantwrite = 1'b0;
        bus.compute_start   = 1'b0;
        run_to_done(1'b1);

        // Frame B: reset in the middle of READ
        bus.out_ready = 1'b1;
        start_frame();
        n = 0;
        while (out_cnt < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        done_due = -1;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_compute_done", 64'(bus.compute_done), 64'(0));
        check("midrst_out_data", 64'({bus.out_data}), 64'(0));
        check("midrst_out_index", 64'(bus.out_index), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Restart without reload must reproduce the original outputs
        start_frame();
        run_to_done(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
